// File: rtl/regfile_access_ctrl.sv
// Sequencer driving a level-sensitive register file's read/write port.
// Executes DUMP (stream all registers out), LOAD (fill registers from a stream) and single WRITE.
module regfile_access_ctrl #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter int SKIP_R0  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [4:0]        cmd_reg,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [4:0]        rf_read_reg1,
  output logic [4:0]        rf_read_reg2,
  input  logic [DATA_W-1:0] rf_read_data1,
  input  logic [DATA_W-1:0] rf_read_data2,
  output logic [4:0]        rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_regWrite,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_index,
  output logic              out_last,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              busy,
  output logic              done,
  output logic [3:0]        dbg_state
);

  // Handshake rule for cmd/out/in: a transfer happens on the rising edge where valid and ready are both high;
  // once out_valid rises, out_data/out_index/out_last stay frozen until that transfer.
  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_RD_ADDR  = 4'd1;
  localparam logic [3:0] S_RD_CAP   = 4'd2;
  localparam logic [3:0] S_OUT0     = 4'd3;
  localparam logic [3:0] S_OUT1     = 4'd4;
  localparam logic [3:0] S_LD_WAIT  = 4'd5;
  localparam logic [3:0] S_WR_SET   = 4'd6;
  localparam logic [3:0] S_WR_PULSE = 4'd7;
  localparam logic [3:0] S_WR_HOLD  = 4'd8;
  localparam logic [3:0] S_FIN      = 4'd9;

  localparam logic [1:0] OP_DUMP  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;

  logic [3:0]        r_state;
  logic [3:0]        w_next;
  logic [1:0]        r_op;
  logic [4:0]        r_index;
  logic [DATA_W-1:0] r_buf0;
  logic [DATA_W-1:0] r_buf1;
  logic [4:0]        r_rd1;
  logic [4:0]        r_rd2;
  logic [4:0]        r_wr_reg;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_regwrite;

  logic [4:0] w_idx_p1;
  logic       w_pair_end;
  logic       w_load_end;
  logic       w_skip;

  assign w_idx_p1   = r_index + 5'd1;
  // Terminal tests are done in 6 bits so index+2 never wraps to 0 on the last pair.
  assign w_pair_end = (({1'b0, r_index} + 6'd2) == 6'(NUM_REGS));
  assign w_load_end = (r_index == 5'(NUM_REGS - 1));
  assign w_skip     = (SKIP_R0 != 0) && (r_wr_reg == 5'd0);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_DUMP:  w_next = S_RD_ADDR;
            OP_LOAD:  w_next = S_LD_WAIT;
            OP_WRITE: w_next = S_WR_SET;
            default:  w_next = S_FIN;
          endcase
        end
      end
      S_RD_ADDR:  w_next = S_RD_CAP;
      S_RD_CAP:   w_next = S_OUT0;
      S_OUT0:     if (out_ready) w_next = S_OUT1;
      S_OUT1:     if (out_ready) w_next = w_pair_end ? S_FIN : S_RD_ADDR;
      S_LD_WAIT:  if (in_valid) w_next = S_WR_SET;
      S_WR_SET:   w_next = S_WR_PULSE;
      S_WR_PULSE: w_next = S_WR_HOLD;
      S_WR_HOLD:  w_next = (r_op == OP_LOAD && !w_load_end) ? S_LD_WAIT : S_FIN;
      S_FIN:      w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_op       <= OP_DUMP;
      r_index    <= 5'd0;
      r_buf0     <= '0;
      r_buf1     <= '0;
      r_rd1      <= 5'd0;
      r_rd2      <= 5'd0;
      r_wr_reg   <= 5'd0;
      r_wr_data  <= '0;
      r_regwrite <= 1'b0;
    end else begin
      r_state    <= w_next;
      // Registered strobe: glitch-free level for the register file, suppressed for r0.
      r_regwrite <= (w_next == S_WR_PULSE) && !w_skip;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_op    <= cmd_op;
            r_index <= 5'd0;
            if (cmd_op == OP_WRITE) begin
              r_wr_reg  <= cmd_reg;
              r_wr_data <= cmd_data;
            end
          end
        end
        S_RD_ADDR: begin
          r_rd1 <= r_index;
          r_rd2 <= w_idx_p1;
        end
        S_RD_CAP: begin
          r_buf0 <= rf_read_data1;
          r_buf1 <= rf_read_data2;
        end
        S_OUT1: begin
          if (out_ready && !w_pair_end) r_index <= r_index + 5'd2;
        end
        S_LD_WAIT: begin
          if (in_valid) begin
            r_wr_reg  <= r_index;
            r_wr_data <= in_data;
          end
        end
        S_WR_HOLD: begin
          if (r_op == OP_LOAD && !w_load_end) r_index <= w_idx_p1;
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready     = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_FIN);
  assign in_ready      = (r_state == S_LD_WAIT);
  assign out_valid     = (r_state == S_OUT0) || (r_state == S_OUT1);
  assign out_data      = (r_state == S_OUT1) ? r_buf1 : ((r_state == S_OUT0) ? r_buf0 : '0);
  assign out_index     = (r_state == S_OUT1) ? w_idx_p1 : ((r_state == S_OUT0) ? r_index : 5'd0);
  assign out_last      = (r_state == S_OUT1) && (w_idx_p1 == 5'(NUM_REGS - 1));
  assign rf_read_reg1  = r_rd1;
  assign rf_read_reg2  = r_rd2;
  assign rf_write_reg  = r_wr_reg;
  assign rf_write_data = r_wr_data;
  assign rf_regWrite   = r_regwrite;
  assign dbg_state     = r_state;

endmodule
